// File: rtl/sti_s8_pkg.sv
// Shared definitions for the two-share S-box round sequencer and its component-function bank.
package sti_s8_pkg;

  localparam int SHARE_W_DEF = 16;
  localparam int ROUNDS_DEF  = 3;

  // Each share is one byte; share0 sits in the low byte, share1 in the high byte.
  localparam int SHARE_BITS = 8;
  localparam int SHARE0_LSB = 0;
  localparam int SHARE1_LSB = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } seq_state_e;

  typedef enum logic [1:0] {
    BANK_IDENTITY  = 2'd0,
    BANK_ROUND_XOR = 2'd1,
    BANK_MIX       = 2'd2
  } bank_mode_e;

endpackage

// File: rtl/sti_s8_round_seq_if.sv
// Valid/ready handshake bundle for the shared S-box state entering and leaving the sequencer.
interface sti_s8_round_seq_if #(
  parameter int SHARE_W = sti_s8_pkg::SHARE_W_DEF
);

  logic               in_valid;
  logic               in_ready;
  logic [SHARE_W-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [SHARE_W-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/sti_s8_round_bank.sv
// Combinational component-function bank: maps the registered shared state to the next round's
// state. MODE selects the function set the parent wires in next to the sequencer.
module sti_s8_round_bank
  import sti_s8_pkg::*;
#(
  parameter int         SHARE_W = SHARE_W_DEF,
  parameter bank_mode_e MODE    = BANK_IDENTITY
) (
  input  logic [SHARE_W-1:0] f_in,
  input  logic [1:0]         f_round,
  output logic [SHARE_W-1:0] f_out
);

  if (MODE == BANK_MIX) begin : g_mix
    logic [SHARE_BITS-1:0] s0;
    logic [SHARE_BITS-1:0] s1;

    assign s0 = f_in[SHARE0_LSB +: SHARE_BITS];
    assign s1 = f_in[SHARE1_LSB +: SHARE_BITS];

    // Each share absorbs a rotated copy of the other, so the two bytes interact every round.
    assign f_out[SHARE0_LSB +: SHARE_BITS] = s0 ^ {s1[6:0], s1[7]} ^ {6'd0, f_round};
    assign f_out[SHARE1_LSB +: SHARE_BITS] = s1 ^ {s0[3:0], s0[7:4]};
  end else if (MODE == BANK_ROUND_XOR) begin : g_round_xor
    assign f_out = f_in ^ SHARE_W'(f_round);
  end else begin : g_identity
    logic unused_round;
    assign unused_round = ^f_round;
    assign f_out        = f_in;
  end

endmodule

// File: rtl/sti_s8_round_seq.sv
// Round sequencer for a two-share threshold S-box: loads shared input, iterates ROUNDS passes
// through an external component-function bank, then presents the result. STI_S8_REFRESH_EN
// enables per-round mask refresh from rnd_data.
module sti_s8_round_seq
  import sti_s8_pkg::*;
#(
  parameter int SHARE_W = SHARE_W_DEF,
  // f_round is two bits wide, so ROUNDS must lie in 1..4.
  parameter int ROUNDS  = ROUNDS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  sti_s8_round_seq_if.slave  hs,
  output logic [SHARE_W-1:0] f_in,
  output logic [1:0]         f_round,
  input  logic [SHARE_W-1:0] f_out,
  input  logic [7:0]         rnd_data,
  output logic               busy
);

  localparam logic [1:0] LAST_ROUND = 2'(ROUNDS - 1);

  seq_state_e         state_q, state_d;
  logic [SHARE_W-1:0] data_q, data_d;
  logic [1:0]         round_q, round_d;
  logic [SHARE_W-1:0] round_val;
  logic               in_ready;
  logic               accept;

`ifdef STI_S8_REFRESH_EN
  // The same byte masks both shares, so share0 ^ share1 is unchanged by the refresh.
  assign round_val = f_out ^ {(SHARE_W / SHARE_BITS){rnd_data}};
`else
  logic unused_rnd;
  assign unused_rnd = ^rnd_data;
  assign round_val  = f_out;
`endif

  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & hs.out_ready);
  assign accept   = hs.in_valid & in_ready;

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
    state_d = state_q;
    data_d  = data_q;
    round_d = round_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = hs.in_data;
          round_d = 2'd0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        data_d = round_val;
        if (round_q == LAST_ROUND) begin
          round_d = 2'd0;
          state_d = DONE;
        end else begin
          round_d = round_q + 2'd1;
        end
      end
      DONE: begin
        // A waiting input is loaded on the same edge the result is taken, with no idle bubble.
        if (accept) begin
          data_d  = hs.in_data;
          round_d = 2'd0;
          state_d = ROUND;
        end else if (hs.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        round_d = 2'd0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      // NOTE: the state register is reset so an aborted evaluation leaves no secret residue behind.
      data_q  <= '0;
      round_q <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments keep all three registers updating from the same pre-edge values.
      state_q <= state_d;
      data_q  <= data_d;
      round_q <= round_d;
    end
  end

  assign hs.in_ready  = in_ready;
  assign hs.out_valid = (state_q == DONE);
  assign hs.out_data  = data_q;
  assign f_in         = data_q;
  assign f_round      = round_q;
  assign busy         = (state_q == ROUND);

endmodule

// File: tb/tb_sti_s8_round_seq.sv
// Self-checking bench for sti_s8_round_seq: directed handshake/reset cases plus randomized
// evaluations against a round-by-round arithmetic model of the shared S-box iteration.
module tb_sti_s8_round_seq;
  import sti_s8_pkg::*;

  localparam int W = 16;
  localparam int R = ROUNDS_DEF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] f_in;
  logic [W-1:0] f_out;
  logic [W-1:0] f_id, f_rx, f_mix;
  logic [1:0]   f_round;
  logic [7:0]   rnd_data;
  logic         busy;
  int           bank_sel;
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] res;

  sti_s8_round_seq_if #(.SHARE_W(W)) hs ();

  always #5 clk = ~clk;

  sti_s8_round_seq #(.SHARE_W(W), .ROUNDS(R)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .hs       (hs),
    .f_in     (f_in),
    .f_round  (f_round),
    .f_out    (f_out),
    .rnd_data (rnd_data),
    .busy     (busy)
  );

  sti_s8_round_bank #(.SHARE_W(W), .MODE(BANK_IDENTITY))  u_bank_id  (.f_in(f_in), .f_round(f_round), .f_out(f_id));
  sti_s8_round_bank #(.SHARE_W(W), .MODE(BANK_ROUND_XOR)) u_bank_rx  (.f_in(f_in), .f_round(f_round), .f_out(f_rx));
  sti_s8_round_bank #(.SHARE_W(W), .MODE(BANK_MIX))       u_bank_mix (.f_in(f_in), .f_round(f_round), .f_out(f_mix));

  always_comb begin
    f_out = f_id;
    if (bank_sel == 1) f_out = f_rx;
    else if (bank_sel == 2) f_out = f_mix;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: one bank round as plain byte arithmetic on the two shares.
  function automatic logic [15:0] bank_ref(input int mode, input logic [15:0] x, input int r);
    logic [7:0] a, b, na, nb;
    a = x[7:0];
    b = x[15:8];
    if (mode == 0) return x;
    if (mode == 1) return x ^ 16'(r);
    na = a ^ 8'((b << 1) | (b >> 7)) ^ 8'(r);
    nb = b ^ 8'((a << 4) | (a >> 4));
    return {nb, na};
  endfunction

  function automatic logic [15:0] mask_of(input logic [7:0] rnd);
`ifdef STI_S8_REFRESH_EN
    return {rnd, rnd};
`else
    return 16'h0000 & {rnd, rnd};
`endif
  endfunction

  task automatic start_txn(input logic [15:0] din, input logic [7:0] rnd);
    int budget;
    budget      = 0;
    hs.in_valid = 1'b1;
    hs.in_data  = din;
    while (!hs.in_ready && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    check("accept_wait", 32'(budget < 50), 32'd1);
    @(posedge clk); #1;
    hs.in_valid = 1'b0;
    rnd_data    = rnd;
  endtask

  task automatic finish_rounds(input logic [15:0] din, input logic [7:0] rnd, input bit glitch,
                               output logic [15:0] result);
    logic [15:0] x;
    x = din;
    for (int r = 0; r < R; r++) begin
      check("round_busy", busy, 1);
      check("round_out_valid", hs.out_valid, 0);
      check("round_index", f_round, r);
      check("round_f_in", f_in, x);
      if (glitch && r == 1) begin
        hs.in_valid = 1'b1;
        hs.in_data  = 16'hFFFF;
        check("glitch_in_ready", hs.in_ready, 0);
      end
      x = bank_ref(bank_sel, x, r) ^ mask_of(rnd);
      @(posedge clk); #1;
      if (glitch) hs.in_valid = 1'b0;
    end
    check("done_out_valid", hs.out_valid, 1);
    check("done_out_data", hs.out_data, x);
    check("done_busy", busy, 0);
    check("done_f_round", f_round, 0);
    result = x;
  endtask

  task automatic stall(input int cycles, input logic [15:0] exp);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      check("stall_out_valid", hs.out_valid, 1);
      check("stall_out_data", hs.out_data, exp);
      check("stall_in_ready", hs.in_ready, 0);
    end
  endtask

  task automatic drain();
    hs.out_ready = 1'b1;
    @(posedge clk); #1;
    hs.out_ready = 1'b0;
    check("drain_out_valid", hs.out_valid, 0);
    check("drain_in_ready", hs.in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] din;
    logic [7:0]  rnd;
    hs.in_valid  = 1'b0;
    hs.in_data   = '0;
    hs.out_ready = 1'b0;
    rnd_data     = 8'h00;
    bank_sel     = 0;

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", hs.in_ready, 1);
    check("reset_out_valid", hs.out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_f_round", f_round, 0);
    check("reset_out_data", hs.out_data, 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity bank: result equals input, rounds 0,1,2 observed.
    bank_sel = 0;
    start_txn(16'hA5C3, 8'h3C);
    finish_rounds(16'hA5C3, 8'h3C, 1'b0, res);
`ifndef STI_S8_REFRESH_EN
    check("identity_a5c3", hs.out_data, 16'hA5C3);
`endif
    drain();

    // Round-index bank from zero, then a stalled DONE followed by back-to-back load.
    bank_sel = 1;
    start_txn(16'h0000, 8'hC6);
    finish_rounds(16'h0000, 8'hC6, 1'b0, res);
`ifndef STI_S8_REFRESH_EN
    check("round_xor_0003", hs.out_data, 16'h0003);
`endif
    hs.in_valid = 1'b1;
    hs.in_data  = 16'h1234;
    stall(5, res);
    hs.out_ready = 1'b1;
    start_txn(16'h1234, 8'h91);
    hs.out_ready = 1'b0;
    check("b2b_restart_valid", hs.out_valid, 0);
    finish_rounds(16'h1234, 8'h91, 1'b0, res);
    drain();

    // Input offered mid-evaluation must be ignored.
    bank_sel = 2;
    start_txn(16'h5EED, 8'h27);
    finish_rounds(16'h5EED, 8'h27, 1'b1, res);
    drain();

`ifdef STI_S8_REFRESH_EN
    bank_sel = 0;
    start_txn(16'h0000, 8'h5A);
    finish_rounds(16'h0000, 8'h5A, 1'b0, res);
    check("refresh_5a5a", hs.out_data, 16'h5A5A);
    check("refresh_unshared", hs.out_data[7:0] ^ hs.out_data[15:8], 0);
    drain();
`endif

    // Reset in the second round cycle discards the evaluation.
    bank_sel = 2;
    start_txn(16'h7E81, 8'h44);
    @(posedge clk); #1;
    check("pre_abort_round", f_round, 1);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", hs.out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_f_round", f_round, 0);
    check("abort_state_reg", hs.out_data, 0);
    check("abort_in_ready", hs.in_ready, 1);
    #20 rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check("abort_quiet_valid", hs.out_valid, 0);
      check("abort_quiet_busy", busy, 0);
    end

    // Randomized evaluations over all bank functions with random output stalls.
    for (int t = 0; t < 24; t++) begin
      bank_sel = int'($urandom_range(0, 2));
      din      = 16'($urandom);
      rnd      = 8'($urandom);
      start_txn(din, rnd);
      finish_rounds(din, rnd, 1'($urandom_range(0, 1)), res);
      stall(int'($urandom_range(0, 3)), res);
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sti_s8_round_seq.md
STI_S8_ROUND_SEQ -- requirements
Module: sti_s8_round_seq

Interface
REQ-001 SHALL have parameter SHARE_W, default 16, meaning width of the shared S-box state (two 8-bit shares, share0 = [7:0], share1 = [15:8]).
REQ-002 SHALL have parameter ROUNDS, default 3, meaning number of TI component-function rounds per S-box evaluation.
REQ-003 SHALL have port clk  input  1  the single clock; all flops on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream shared state is valid.
REQ-006 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-007 SHALL have port in_data  input  SHARE_W  shared S-box input.
REQ-008 SHALL have port f_in  output  SHARE_W  registered state driven to the component-function bank.
REQ-009 SHALL have port f_round  output  2  current round index, 0..ROUNDS-1, selecting the bank's round functions.
REQ-010 SHALL have port f_out  input  SHARE_W  combinational bank result, one bit per component function.
REQ-011 SHALL have port rnd_data  input  8  fresh randomness for mask refresh.
REQ-012 SHALL have port out_valid  output  1  out_data holds a finished result.
REQ-013 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-014 SHALL have port out_data  output  SHARE_W  shared S-box output.
REQ-015 SHALL have port busy  output  1  high in ROUND state.

Function
REQ-016 SHALL implement FSM states IDLE, ROUND, DONE.
REQ-017 SHALL drive in_ready = (state==IDLE) | (state==DONE & out_ready).
REQ-018 On in_valid & in_ready at an edge: state_reg <= in_data, f_round <= 0, FSM -> ROUND.
REQ-019 In ROUND, f_in SHALL equal state_reg; each edge state_reg <= f_out (refreshed per REQ-027), f_round increments.
REQ-020 After the edge registering round ROUNDS-1, FSM SHALL enter DONE and f_round SHALL return to 0; no wrap beyond ROUNDS-1.
REQ-021 Latency SHALL be exactly ROUNDS cycles from accept edge to out_valid high (3 for default).
REQ-022 In DONE, out_valid = 1, out_data = state_reg, both held stable until out_ready.
REQ-023 DONE & out_ready & !in_valid SHALL go to IDLE; DONE & out_ready & in_valid SHALL load new in_data and go to ROUND in the same edge (back-to-back, no bubble).
REQ-024 in_valid during ROUND SHALL be ignored (in_ready = 0); no state corruption.
REQ-025 out_valid SHALL be 0 in IDLE and ROUND; out_data SHALL equal state_reg at all times.

Reset
REQ-026 rst_n low SHALL immediately force FSM IDLE, state_reg 0, f_round 0, out_valid 0, busy 0, in_ready 1 (after release); reset mid-ROUND discards the evaluation with no output.

Configuration
REQ-027 With STI_S8_REFRESH_EN defined, each round update SHALL be state_reg <= f_out ^ {rnd_data, rnd_data} (same mask on both shares, unshared value preserved); without it, state_reg <= f_out and rnd_data SHALL be unused.

Structure
REQ-028 Shared package sti_s8_pkg SHALL hold the FSM state enum, SHARE_W and ROUNDS defaults, and share-slice constants.
REQ-029 Round-counter/FSM SHALL be inline; the component-function bank SHALL be external, instantiated by the parent as sub-module sti_s8_round_bank.

Verification
REQ-030 Identity bank (f_out=f_in), in_data=16'hA5C3 accepted at edge T -> out_valid at edge T+3, out_data=16'hA5C3, f_round seen 0,1,2.
REQ-031 Bank f_out=f_in ^ {14'b0,f_round}, input 16'h0000 -> out_data=16'h0003 (0^0^1^2).
REQ-032 out_ready held 0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0; then out_ready=1 with in_valid=1, in_data=16'h1234 -> new evaluation starts same edge.
REQ-033 in_valid pulsed with 16'hFFFF during ROUND -> ignored, result still from original input.
REQ-034 rst_n low at second ROUND cycle -> out_valid never asserts, state_reg=0, FSM IDLE.
REQ-035 STI_S8_REFRESH_EN, identity bank, rnd_data=8'h5A every cycle, input 16'h0000 -> out_data=16'h5A5A, share0 XOR share1 = 0.
